// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
// Shared processor-pipeline constants used by the memory port arbiter:
//   - arbState_t       : arbiter FSM state encoding
//   - MAX_WAIT_DEFAULT : default memory-ready timeout in busy cycles
//   - waitCountWidth() : width of a counter that must hold 0..maxWait
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_D = 2'd1,
        BUSY_I = 2'd2,
        RESP   = 2'd3
    } arbState_t;

    localparam int MAX_WAIT_DEFAULT = 16;

    // ceil(log2(maxWait+1)): enough bits to count all the way up to maxWait.
    function automatic int waitCountWidth(input int maxWait);
        return (maxWait < 1) ? 1 : $clog2(maxWait + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch port, data port, memory port and status of the arbiter.
//   modport master : the arbiter itself (drives responses, stalls, memory bus)
//   modport slave  : the surroundings (requesters and the memory)
// Fetch : ireq, iaddr -> irdata, ivalid, StallF
// Data  : dreq, dwe, daddr, dwdata -> drdata, dvalid, StallM
// Memory: mem_req, mem_we, mem_addr, mem_wdata <- mem_rdata, mem_ready
// Status: bus_err (sticky timeout flag)
// -----------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          ireq;
    logic [AW-1:0] iaddr;
    logic [DW-1:0] irdata;
    logic          ivalid;
    logic          StallF;

    logic          dreq;
    logic          dwe;
    logic [AW-1:0] daddr;
    logic [DW-1:0] dwdata;
    logic [DW-1:0] drdata;
    logic          dvalid;
    logic          StallM;

    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;

    logic          bus_err;

    modport master (
        input  ireq, iaddr, dreq, dwe, daddr, dwdata, mem_rdata, mem_ready,
        output irdata, ivalid, StallF, drdata, dvalid, StallM,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );

    modport slave (
        output ireq, iaddr, dreq, dwe, daddr, dwdata, mem_rdata, mem_ready,
        input  irdata, ivalid, StallF, drdata, dvalid, StallM,
               mem_req, mem_we, mem_addr, mem_wdata, bus_err
    );
endinterface

// File: rtl/mem_port_arbiter_wait_timer.sv
// -----------------------------------------------------------------------------
// wait_timer
// Counts busy cycles spent waiting for the memory.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : zero the count (asserted on the granting cycle)
//   enable     : one more busy cycle without mem_ready
//   expired    : this enabled cycle is the MAX_WAIT-th one without mem_ready
// -----------------------------------------------------------------------------
module wait_timer
    import mem_port_arbiter_pkg::*;
#(
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CW = waitCountWidth(MAX_WAIT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(MAX_WAIT - 1);

    logic [CW-1:0] countReg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            countReg <= '0;
        end else if (clear) begin
            countReg <= '0;
        end else if (enable) begin
            countReg <= countReg + CW'(1);
        end
    end

    // Fires during the cycle whose increment would make the count reach
    // MAX_WAIT, so the arbiter leaves busy after exactly MAX_WAIT cycles.
    assign expired = enable && (countReg == LAST_COUNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between the fetch and the data side of the
// pipeline. Data requests win over fetch requests; one access is in flight at
// a time; a busy access that sees no mem_ready for MAX_WAIT cycles completes
// with zero data and sets the sticky bus_err flag.
//   clk   : clock (rising edge)
//   rst_n : asynchronous active-low reset
//   bus   : mem_port_arbiter_if.master (fetch, data, memory and status signals)
// -----------------------------------------------------------------------------
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW       = 32,
    parameter int DW       = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEFAULT
) (
    input logic clk,
    input logic rst_n,
    mem_port_arbiter_if.master bus
);
    arbState_t     stateReg, stateNext;
    logic          memReqReg, memReqNext;
    logic          memWeReg, memWeNext;
    logic [AW-1:0] memAddrReg, memAddrNext;
    logic [DW-1:0] memWdataReg, memWdataNext;
    logic [DW-1:0] irdataReg, irdataNext;
    logic [DW-1:0] drdataReg, drdataNext;
    logic          ivalidReg, ivalidNext;
    logic          dvalidReg, dvalidNext;
    logic          busErrReg, busErrNext;

    logic          timerClear;
    logic          timerEnable;
    logic          timerExpired;

    // The counter restarts whenever a request is granted out of IDLE and
    // advances on every busy cycle that did not complete.
    assign timerClear  = (stateReg == IDLE) && (bus.dreq || bus.ireq);
    assign timerEnable = ((stateReg == BUSY_D) || (stateReg == BUSY_I)) && !bus.mem_ready;

    wait_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) waitTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timerClear),
        .enable  (timerEnable),
        .expired (timerExpired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg    <= IDLE;
            memReqReg   <= 1'b0;
            memWeReg    <= 1'b0;
            memAddrReg  <= '0;
            memWdataReg <= '0;
            irdataReg   <= '0;
            drdataReg   <= '0;
            ivalidReg   <= 1'b0;
            dvalidReg   <= 1'b0;
            busErrReg   <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            memReqReg   <= memReqNext;
            memWeReg    <= memWeNext;
            memAddrReg  <= memAddrNext;
            memWdataReg <= memWdataNext;
            irdataReg   <= irdataNext;
            drdataReg   <= drdataNext;
            ivalidReg   <= ivalidNext;
            dvalidReg   <= dvalidNext;
            busErrReg   <= busErrNext;
        end
    end

    always_comb begin
        stateNext    = stateReg;
        memReqNext   = memReqReg;
        memWeNext    = memWeReg;
        memAddrNext  = memAddrReg;
        memWdataNext = memWdataReg;
        irdataNext   = irdataReg;
        drdataNext   = drdataReg;
        ivalidNext   = 1'b0;
        dvalidNext   = 1'b0;
        busErrNext   = busErrReg;

        case (stateReg)
            IDLE: begin
                if (bus.dreq) begin
                    stateNext    = BUSY_D;
                    memReqNext   = 1'b1;
                    memWeNext    = bus.dwe;
                    memAddrNext  = bus.daddr;
                    memWdataNext = bus.dwdata;
                end else if (bus.ireq) begin
                    stateNext    = BUSY_I;
                    memReqNext   = 1'b1;
                    memWeNext    = 1'b0;
                    memAddrNext  = bus.iaddr;
                    memWdataNext = '0;
                end
            end

            BUSY_D: begin
                // mem_ready takes priority over a timeout on the same cycle.
                if (bus.mem_ready || timerExpired) begin
                    stateNext  = RESP;
                    memReqNext = 1'b0;
                    dvalidNext = 1'b1;
                    if (!bus.mem_ready) begin
                        busErrNext = 1'b1;
                    end
                    // A store never disturbs the last load result.
                    if (!memWeReg) begin
                        drdataNext = bus.mem_ready ? bus.mem_rdata : '0;
                    end
                end
            end

            BUSY_I: begin
                if (bus.mem_ready || timerExpired) begin
                    stateNext  = RESP;
                    memReqNext = 1'b0;
                    ivalidNext = 1'b1;
                    irdataNext = bus.mem_ready ? bus.mem_rdata : '0;
                    if (!bus.mem_ready) begin
                        busErrNext = 1'b1;
                    end
                end
            end

            RESP: begin
                // The valid pulse is already registered; requests wait a cycle.
                stateNext = IDLE;
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.mem_req   = memReqReg;
    assign bus.mem_we    = memWeReg;
    assign bus.mem_addr  = memAddrReg;
    assign bus.mem_wdata = memWdataReg;
    assign bus.irdata    = irdataReg;
    assign bus.drdata    = drdataReg;
    assign bus.ivalid    = ivalidReg;
    assign bus.dvalid    = dvalidReg;
    assign bus.bus_err   = busErrReg;

    // Stalls are combinational so the pipeline freezes in the request cycle.
    assign bus.StallF = bus.ireq && !ivalidReg;
    assign bus.StallM = bus.dreq && !dvalidReg;

endmodule
